// File: rtl/alu_seq_16bit.sv
// Multi-cycle ALU feeding the 16-bit accumulator: single-cycle logic/arith, shift-add MUL, serial SHL.
// Optional macro ALU_OVERFLOW_EN adds signed-overflow tracking for ADD/SUB; otherwise overflow is tied 0.
module alu_seq_16bit #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             ac_load,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             overflow
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_MUL   = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             carry_q, carry_d;

  logic             fin;
  logic [WIDTH-1:0] fin_res;
  logic             fin_carry;
  logic [WIDTH:0]   sum17;
  logic [WIDTH:0]   diff17;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi_n;
  logic [WIDTH-1:0] mul_lo_n;

  assign sum17  = {1'b0, a} + {1'b0, b};
  assign diff17 = {1'b0, a} - {1'b0, b};

  // {hi,lo} is the shifting product register; lo starts as the multiplier and drains from bit 0.
  assign mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
  assign mul_hi_n = mul_sum[WIDTH:1];
  assign mul_lo_n = {mul_sum[0], lo_q[WIDTH-1:1]};

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    cnt_d     = cnt_q;
    fin       = 1'b0;
    fin_res   = '0;
    fin_carry = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          case (op)
            3'b000: begin fin = 1'b1; fin_res = sum17[WIDTH-1:0]; fin_carry = sum17[WIDTH]; end
            3'b001: begin fin = 1'b1; fin_res = diff17[WIDTH-1:0]; fin_carry = ~diff17[WIDTH]; end
            3'b010: begin fin = 1'b1; fin_res = a & b; end
            3'b011: begin fin = 1'b1; fin_res = a | b; end
            3'b100: begin fin = 1'b1; fin_res = a ^ b; end
            3'b101: begin fin = 1'b1; fin_res = ~a; end
            3'b110: begin
              state_d = S_MUL;
              a_d     = a;
              hi_d    = '0;
              lo_d    = b;
              cnt_d   = 4'd0;
            end
            default: begin
              if (b[3:0] != 4'd0) begin
                state_d = S_SHIFT;
                lo_d    = a;
                cnt_d   = b[3:0];
              end else begin
                fin     = 1'b1;
                fin_res = a;
              end
            end
          endcase
        end
      end
      S_MUL: begin
        hi_d  = mul_hi_n;
        lo_d  = mul_lo_n;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          fin       = 1'b1;
          fin_res   = mul_lo_n;
          fin_carry = |mul_hi_n;
        end
      end
      S_SHIFT: begin
        lo_d  = lo_q << 1;
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          fin       = 1'b1;
          fin_res   = lo_q << 1;
          fin_carry = lo_q[WIDTH-1];
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (fin) state_d = S_DONE;
  end

  always_comb begin
    result_d = result_q;
    zero_d   = zero_q;
    carry_d  = carry_q;
    if (fin) begin
      result_d = fin_res;
      zero_d   = (fin_res == '0);
      carry_d  = fin_carry;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      cnt_q    <= 4'd0;
      result_q <= '0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      carry_q  <= carry_d;
    end
  end

`ifdef ALU_OVERFLOW_EN
  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q;
    if (fin) ovf_d = 1'b0;
    if (state_q == S_IDLE && start && op == 3'b000)
      ovf_d = (a[WIDTH-1] == b[WIDTH-1]) && (sum17[WIDTH-1] != a[WIDTH-1]);
    else if (state_q == S_IDLE && start && op == 3'b001)
      ovf_d = (a[WIDTH-1] != b[WIDTH-1]) && (diff17[WIDTH-1] != a[WIDTH-1]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  assign overflow = ovf_q;
`else
  assign overflow = 1'b0;
`endif

  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_DONE);
  assign ac_load = done;
  assign result  = result_q;
  assign zero    = zero_q;
  assign carry   = carry_q;

endmodule
